agc_central_regs: RTL and testbench

- Parametrised central register bank for the AGC datapath. It replaces the fixed set of eight 16-bit registers with NREG configurable-width registers plus four AGC editing registers: CYR, SR, CYL and EDOP.
- It adds an involuntary-counter increment port (PINC/MINC) for the interrupt/IO side. This port performs ones'-complement read-modify-write with overflow reporting and arbitrates against CPU writes.
- It sits between the memory/ALU muxing and the register consumers. It holds the register state that the sequencer's write enables act on.

---
 rtl/agc_central_regs.sv | 162 ++++++++++++++++
 tb/tb_agc_central_regs.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_central_regs.sv
// AGC central register bank: plain registers, CYR/SR/CYL/EDOP editing
// registers, and a ones'-complement PINC/MINC counter port.
module agc_central_regs #(
  parameter int WIDTH      = 16,
  parameter int NREG       = 8,
  parameter int ADDR_W     = 5,
  parameter int EDIT_BASE  = 16,
  parameter int EDOP_SHIFT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              ctr_req,
  input  logic [ADDR_W-1:0] ctr_addr,
  input  logic              ctr_dir,
  output logic              ctr_ack,
  output logic              ctr_ovf
);

  typedef enum logic [1:0] {IDLE, RMW, ACK} state_t;

  localparam int DW = WIDTH - 1;
  localparam logic [ADDR_W-1:0] EB = ADDR_W'(EDIT_BASE);

  logic [WIDTH-1:0]  plain_q [NREG];
  logic [WIDTH-1:0]  plain_d [NREG];
  logic [WIDTH-1:0]  edit_q  [4];
  logic [WIDTH-1:0]  edit_d  [4];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              lat_dir_q, lat_dir_d;
  logic              ovf_q, ovf_d;

  logic [DW-1:0]     wd, r_cyr, r_sr, r_cyl, r_edop;
  logic [WIDTH-1:0]  cv;
  logic              cv_hit;
  logic [DW-1:0]     cd, ce;
  logic              co;

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_data_a = plain_q[i];
      if (rd_addr_b == ADDR_W'(i)) rd_data_b = plain_q[i];
    end
    for (int j = 0; j < 4; j++) begin
      if (rd_addr_a == EB + ADDR_W'(j)) rd_data_a = edit_q[j];
      if (rd_addr_b == EB + ADDR_W'(j)) rd_data_b = edit_q[j];
    end
  end

  assign wd     = wr_data[DW-1:0];
  assign r_cyr  = {wd[0], wd[DW-1:1]};
  assign r_sr   = {wd[DW-1], wd[DW-1:1]};
  assign r_cyl  = {wd[DW-2:0], wd[DW-1]};
  assign r_edop = wd >> EDOP_SHIFT;

  always_comb begin
    cv     = '0;
    cv_hit = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (lat_addr_q == ADDR_W'(i)) begin
        cv     = plain_q[i];
        cv_hit = 1'b1;
      end
    end
  end

  // End-around carry; the +max/-max wraps go to the same-sign zero.
  always_comb begin
    cd = cv[DW-1:0];
    ce = cd;
    co = 1'b0;
    if (!lat_dir_q) begin
      if (&cd) begin
        ce = DW'(1);
      end else if (cd == {1'b0, {(DW-1){1'b1}}}) begin
        ce = '0;
        co = 1'b1;
      end else begin
        ce = cd + DW'(1);
      end
    end else begin
      if (cd == '0) begin
        ce = {{(DW-1){1'b1}}, 1'b0};
      end else if (cd == {1'b1, {(DW-1){1'b0}}}) begin
        ce = '1;
        co = 1'b1;
      end else begin
        ce = cd - DW'(1);
      end
    end
  end

  always_comb begin
    plain_d    = plain_q;
    edit_d     = edit_q;
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    lat_dir_d  = lat_dir_q;
    ovf_d      = ovf_q;
    if (wr_en) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_addr == ADDR_W'(i)) plain_d[i] = wr_data;
      end
      if (wr_addr == EB)               edit_d[0] = {r_cyr[DW-1], r_cyr};
      if (wr_addr == EB + ADDR_W'(1))  edit_d[1] = {r_sr[DW-1], r_sr};
      if (wr_addr == EB + ADDR_W'(2))  edit_d[2] = {r_cyl[DW-1], r_cyl};
      if (wr_addr == EB + ADDR_W'(3))  edit_d[3] = {r_edop[DW-1], r_edop};
    end
    unique case (state_q)
      IDLE: begin
        if (ctr_req) begin
          lat_addr_d = ctr_addr;
          lat_dir_d  = ctr_dir;
          state_d    = RMW;
        end
      end
      RMW: begin
        // A CPU write to the same register wins; retry next cycle.
        if (!(wr_en && wr_addr == lat_addr_q)) begin
          for (int i = 0; i < NREG; i++) begin
            if (lat_addr_q == ADDR_W'(i)) plain_d[i] = {ce[DW-1], ce};
          end
          ovf_d   = cv_hit & co;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) plain_q[i] <= '0;
      for (int j = 0; j < 4; j++) edit_q[j] <= '0;
      state_q    <= IDLE;
      lat_addr_q <= '0;
      lat_dir_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      plain_q    <= plain_d;
      edit_q     <= edit_d;
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      lat_dir_q  <= lat_dir_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ctr_ack = (state_q == ACK);
  assign ctr_ovf = (state_q == ACK) & ovf_q;

endmodule

// File: tb/tb_agc_central_regs.sv
// Scoreboard bench for agc_central_regs: editing transforms, PINC/MINC,
// CPU/counter arbitration, held requests and asynchronous reset.
module tb_agc_central_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, ctr_addr;
  logic [15:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, ctr_req, ctr_dir, ctr_ack, ctr_ovf;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] val;
    logic        ovf;
    int          edges;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  agc_central_regs dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ctr_req(ctr_req), .ctr_addr(ctr_addr), .ctr_dir(ctr_dir),
    .ctr_ack(ctr_ack), .ctr_ovf(ctr_ovf)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [4:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_ack(output int edges, output logic ovf, output bit to);
    edges = 0; ovf = 1'b0; to = 1'b1;
    while (to && edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (ctr_ack) begin
        ovf = ctr_ovf; to = 1'b0;
      end
    end
    ctr_req = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    #3;
    rd_addr_a = 5'd3;
    #1;
    n_vec++;
    if (rd_data_a !== 16'h0) begin
      n_err++; $display("FAIL reset_rd: got %h want 0000", rd_data_a);
    end
    n_vec++;
    if (ctr_ack !== 1'b0) begin
      n_err++; $display("FAIL reset_ack: got %b want 0", ctr_ack);
    end
    @(posedge clk); #1; reset = 1'b0;
    cpu_write(5'd3, 16'h1234);
    n_vec++;
    if (rd_data_a !== 16'h1234) begin
      n_err++; $display("FAIL load_r3: got %h want 1234", rd_data_a);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (rd_data_a !== 16'h0 || ctr_ack !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: got %h ack %b want 0000 ack 0", rd_data_a, ctr_ack);
    end
    @(posedge clk); #1; reset = 1'b0;
    ctr_addr = 5'd6; ctr_dir = 1'b1; ctr_req = 1'b1;
    @(posedge clk); #1;
    #2 reset = 1'b1; ctr_req = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ctr_ack) seen = 1'b1;
    end
    rd_addr_a = 5'd6; #1;
    n_vec++;
    if (seen || rd_data_a !== 16'h0) begin
      n_err++;
      $display("FAIL rmw_abort: ack %b r6 %h want ack 0 r6 0000", seen, rd_data_a);
    end
  endtask

  task automatic test_edit();
    logic [4:0]  ea [5] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd10};
    logic [15:0] ed [5] = '{16'h0001, 16'h4000, 16'h4000, 16'h7F80, 16'hBEEF};
    logic [15:0] ev [5] = '{16'hC000, 16'hE000, 16'h0001, 16'h00FF, 16'h0000};
    exp_t x;
    for (int k = 0; k < 5; k++) begin
      x.addr = ea[k]; x.val = ev[k]; x.ovf = 1'b0; x.edges = 0;
      sb.push_back(x);
      cpu_write(ea[k], ed[k]);
      x = sb.pop_front();
      rd_addr_b = x.addr; #1;
      n_vec++;
      if (rd_data_b !== x.val) begin
        n_err++;
        $display("FAIL edit_%0d: got %h want %h", x.addr, rd_data_b, x.val);
      end
    end
    cpu_write(5'd4, 16'h0000);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'hAAAA;
    rd_addr_a = 5'd4; #1;
    n_vec++;
    if (rd_data_a !== 16'h0000) begin
      n_err++; $display("FAIL rd_old: got %h want 0000", rd_data_a);
    end
    @(posedge clk); #1; wr_en = 1'b0;
    n_vec++;
    if (rd_data_a !== 16'hAAAA) begin
      n_err++; $display("FAIL rd_new: got %h want aaaa", rd_data_a);
    end
  endtask

  task automatic test_inc_table(input logic [4:0] a, input int n,
                                input logic [15:0] iv [3], input logic dv [3],
                                input logic [15:0] xv [3], input logic xo [3],
                                input bit preload);
    int e; logic o; bit to; exp_t x;
    for (int k = 0; k < n; k++) begin
      if (preload) cpu_write(a, iv[k]);
      x.addr = a; x.val = xv[k]; x.ovf = xo[k]; x.edges = 2;
      sb.push_back(x);
      ctr_addr = a; ctr_dir = dv[k]; ctr_req = 1'b1;
      wait_ack(e, o, to);
      x = sb.pop_front();
      n_vec++;
      if (to || e != x.edges) begin
        n_err++;
        $display("FAIL inc_lat r%0d#%0d: got %0d edges to=%0b want %0d",
                 a, k, e, to, x.edges);
      end
      n_vec++;
      if (o !== x.ovf) begin
        n_err++; $display("FAIL inc_ovf r%0d#%0d: got %b want %b", a, k, o, x.ovf);
      end
      rd_addr_a = x.addr; #1;
      n_vec++;
      if (rd_data_a !== x.val) begin
        n_err++;
        $display("FAIL inc_val r%0d#%0d: got %h want %h", a, k, rd_data_a, x.val);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pinc();
    logic [15:0] iv [3] = '{16'h3FFE, 16'h0, 16'h0};
    logic        dv [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] xv [3] = '{16'h3FFF, 16'h0000, 16'h0};
    logic        xo [3] = '{1'b0, 1'b1, 1'b0};
    cpu_write(5'd2, iv[0]);
    test_inc_table(5'd2, 2, iv, dv, xv, xo, 1'b0);
  endtask

  task automatic test_minc();
    logic [15:0] iv [3] = '{16'h0000, 16'hC000, 16'hFFFF};
    logic        dv [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] xv [3] = '{16'hFFFE, 16'hFFFF, 16'h0001};
    logic        xo [3] = '{1'b0, 1'b1, 1'b0};
    test_inc_table(5'd5, 3, iv, dv, xv, xo, 1'b1);
  endtask

  task automatic test_nonplain_inc();
    logic [15:0] iv [3] = '{16'h0, 16'h0, 16'h0};
    logic        dv [3] = '{1'b1, 1'b1, 1'b1};
    logic [15:0] xv [3] = '{16'hC000, 16'h0, 16'h0};
    logic        xo [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] uv [3] = '{16'h0000, 16'h0, 16'h0};
    test_inc_table(5'd16, 1, iv, dv, xv, xo, 1'b0);
    test_inc_table(5'd9, 1, iv, dv, uv, xo, 1'b0);
  endtask

  task automatic test_conflict();
    int e; logic o; bit to; exp_t x;
    cpu_write(5'd1, 16'h0000);
    cpu_write(5'd7, 16'h0005);
    x.addr = 5'd1; x.val = 16'h0011; x.ovf = 1'b0; x.edges = 3;
    sb.push_back(x);
    ctr_addr = 5'd1; ctr_dir = 1'b0; ctr_req = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 16'h0010;
    @(posedge clk); #1;
    wr_en = 1'b0;
    n_vec++;
    if (ctr_ack !== 1'b0) begin
      n_err++; $display("FAIL conflict_stall: got ack %b want 0", ctr_ack);
    end
    wait_ack(e, o, to);
    x = sb.pop_front();
    n_vec++;
    if (to || e + 2 != x.edges || o !== x.ovf) begin
      n_err++;
      $display("FAIL conflict_ack: got %0d edges ovf %b want %0d ovf %b",
               e + 2, o, x.edges, x.ovf);
    end
    rd_addr_a = x.addr; #1;
    n_vec++;
    if (rd_data_a !== x.val) begin
      n_err++; $display("FAIL conflict_val: got %h want %h", rd_data_a, x.val);
    end
    @(posedge clk); #1;
    x.addr = 5'd7; x.val = 16'h0006; x.ovf = 1'b0; x.edges = 2;
    sb.push_back(x);
    ctr_addr = 5'd7; ctr_dir = 1'b0; ctr_req = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 16'h5555;
    wait_ack(e, o, to);
    wr_en = 1'b0;
    x = sb.pop_front();
    rd_addr_a = x.addr; rd_addr_b = 5'd4; #1;
    n_vec++;
    if (to || e + 1 != x.edges || rd_data_a !== x.val || rd_data_b !== 16'h5555) begin
      n_err++;
      $display("FAIL simul_wr: got %0d edges r7 %h r4 %h want %0d r7 %h r4 5555",
               e + 1, rd_data_a, rd_data_b, x.edges, x.val);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acks; bit prev, dbl; exp_t x;
    cpu_write(5'd0, 16'h0000);
    x.addr = 5'd0; x.val = 16'h0002; x.ovf = 1'b0; x.edges = 2;
    sb.push_back(x);
    acks = 0; prev = 1'b0; dbl = 1'b0;
    ctr_addr = 5'd0; ctr_dir = 1'b0; ctr_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ctr_ack) acks++;
      if (ctr_ack && prev) dbl = 1'b1;
      prev = ctr_ack;
    end
    ctr_req = 1'b0;
    @(posedge clk); #1;
    x = sb.pop_front();
    n_vec++;
    if (acks != x.edges || dbl) begin
      n_err++;
      $display("FAIL held_acks: got %0d acks dbl %b want %0d single", acks, dbl, x.edges);
    end
    rd_addr_a = x.addr; #1;
    n_vec++;
    if (rd_data_a !== x.val) begin
      n_err++; $display("FAIL held_val: got %h want %h", rd_data_a, x.val);
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ctr_req = 1'b0; ctr_addr = '0; ctr_dir = 1'b0;
    test_reset();
    test_edit();
    test_pinc();
    test_minc();
    test_nonplain_inc();
    test_conflict();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
